div_arbiter: RTL and testbench

//  Shares one sequential divider datapath (and its controller) between two requesters.

---
 rtl/div_arbiter.sv | 125 ++++++++++++
 tb/tb_div_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one sequential divider between two requesters.
// Handles grant, operand capture, start pulse, result return, divide-by-zero and timeout.
module div_arbiter #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 31,
   parameter int CNT_W   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] dvd0,
   input  logic [WIDTH-1:0] dvs0,
   input  logic [WIDTH-1:0] dvd1,
   input  logic [WIDTH-1:0] dvs1,
   output logic             ack0,
   output logic             ack1,
   output logic             res_err,
   output logic [WIDTH-1:0] res_q,
   output logic [WIDTH-1:0] res_r,
   output logic             busy,
   output logic             div_start,
   output logic [WIDTH-1:0] div_dvd,
   output logic [WIDTH-1:0] div_dvs,
   input  logic             div_valid,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic             gnt_id;

   logic             grant_id;
   logic [WIDTH-1:0] sel_dvd;
   logic [WIDTH-1:0] sel_dvs;

   // Handshake: a requester raises reqN and holds it with stable operands; the
   // transaction is complete in the single cycle ackN is high (res_* valid then),
   // and reqN must be dropped in that cycle. Requests are only sampled in IDLE.
   always_comb begin
      grant_id = (req0 && req1) ? ~last_grant : req1;
      sel_dvd  = grant_id ? dvd1 : dvd0;
      sel_dvs  = grant_id ? dvs1 : dvs0;
   end

   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         gnt_id     <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         res_err    <= 1'b0;
         res_q      <= '0;
         res_r      <= '0;
         busy       <= 1'b0;
         div_start  <= 1'b0;
         div_dvd    <= '0;
         div_dvs    <= '0;
      end else begin
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt_id     <= grant_id;
                  last_grant <= grant_id;
                  div_dvd    <= sel_dvd;
                  div_dvs    <= sel_dvs;
                  busy       <= 1'b1;
                  // Zero divisor short-circuits straight to completion.
                  if (sel_dvs == '0) begin
                     res_err <= 1'b1;
                     res_q   <= '1;
                     res_r   <= sel_dvd;
                     ack0    <= ~grant_id;
                     ack1    <= grant_id;
                     state   <= DONE;
                  end else begin
                     div_start <= 1'b1;
                     state     <= START;
                  end
               end
            end
            START: begin
               cnt   <= '0;
               state <= RUN;
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (div_valid) begin
                  res_err <= 1'b0;
                  res_q   <= div_q;
                  res_r   <= div_r;
                  ack0    <= ~gnt_id;
                  ack1    <= gnt_id;
                  state   <= DONE;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  res_err <= 1'b1;
                  res_q   <= '0;
                  res_r   <= '0;
                  ack0    <= ~gnt_id;
                  ack1    <= gnt_id;
                  state   <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: behavioural divider model, scoreboard of
// expected completions popped on each ack, and a single summary line.
module tb_div_arbiter;
   localparam int WIDTH     = 8;
   localparam int TIMEOUT   = 31;
   localparam int CNT_W     = 5;
   localparam int MODEL_LAT = 18;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd2;

   logic             clk;
   logic             reset;
   logic             req0, req1;
   logic [WIDTH-1:0] dvd0, dvs0, dvd1, dvs1;
   logic             ack0, ack1, res_err, busy, div_start;
   logic [WIDTH-1:0] res_q, res_r, div_dvd, div_dvs;
   logic             div_valid;
   logic [WIDTH-1:0] div_q, div_r;
   logic [1:0]       dbg_state;

   int checks = 0;
   int errors = 0;
   int ack0_cnt = 0;
   int ack1_cnt = 0;
   int start_cnt = 0;
   bit model_never = 0;
   bit model_busy = 0;
   logic prev_ack = 0;
   logic prev_start = 0;
   logic [33:0] exp_q[$];

   div_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1),
      .dvd0(dvd0), .dvs0(dvs0), .dvd1(dvd1), .dvs1(dvs1),
      .ack0(ack0), .ack1(ack1),
      .res_err(res_err), .res_q(res_q), .res_r(res_r),
      .busy(busy), .div_start(div_start),
      .div_dvd(div_dvd), .div_dvs(div_dvs),
      .div_valid(div_valid), .div_q(div_q), .div_r(div_r),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic id, input logic err, input logic [7:0] q,
                           input logic [7:0] r, input logic [7:0] dvd, input logic [7:0] dvs);
      exp_q.push_back({id, err, q, r, dvd, dvs});
   endtask

   // divider model: result MODEL_LAT negedges after the start pulse is seen
   initial begin
      logic [WIDTH-1:0] a, b;
      div_valid = 1'b0;
      div_q     = '0;
      div_r     = '0;
      forever begin
         @(negedge clk);
         if (div_start === 1'b1 && !model_never) begin
            model_busy = 1'b1;
            a = div_dvd;
            b = div_dvs;
            repeat (MODEL_LAT - 1) @(negedge clk);
            div_q     = (b != 0) ? a / b : '0;
            div_r     = (b != 0) ? a % b : '0;
            div_valid = 1'b1;
            @(negedge clk);
            div_valid  = 1'b0;
            div_q      = '0;
            div_r      = '0;
            model_busy = 1'b0;
         end
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      logic [33:0] e;
      if (reset === 1'b1) begin
         if (div_start === 1'b1) begin
            start_cnt++;
            check("start_pulse_width", prev_start, 1'b0);
         end
         if (ack0 === 1'b1 || ack1 === 1'b1) begin
            if (ack0) ack0_cnt++;
            if (ack1) ack1_cnt++;
            check("ack_onehot", ack0 & ack1, 1'b0);
            check("ack_pulse_width", prev_ack, 1'b0);
            check("ack_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("ack_id", ack1, e[33]);
               check("res_err", res_err, e[32]);
               check("res_q", res_q, e[31:24]);
               check("res_r", res_r, e[23:16]);
               check("div_dvd", div_dvd, e[15:8]);
               check("div_dvs", div_dvs, e[7:0]);
               check("busy_in_done", busy, 1'b1);
            end
         end
      end
      prev_ack   = ack0 | ack1;
      prev_start = div_start;
   end

   // driver tasks
   task automatic do_reset();
      reset = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("rst_state", dbg_state, S_IDLE);
      check("rst_busy", busy, 1'b0);
      check("rst_ack", {ack0, ack1}, 2'b00);
      check("rst_start", div_start, 1'b0);
      check("rst_res", {res_err, res_q, res_r}, '0);
      check("rst_ops", {div_dvd, div_dvs}, '0);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_ack(input logic id, input int budget, output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (((id ? ack1 : ack0) !== 1'b1) && waited < budget);
      check(id ? "wait_ack1" : "wait_ack0", id ? ack1 : ack0, 1'b1);
      if (id) req1 = 1'b0;
      else    req0 = 1'b0;
   endtask

   initial begin
      int w, s0, a0, n;
      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      dvd0 = '0; dvs0 = '0; dvd1 = '0; dvs1 = '0;
      do_reset();

      // single requester 0
      dvd0 = 8'd100; dvs0 = 8'd7;
      push_exp(1'b0, 1'b0, 8'd14, 8'd2, 8'd100, 8'd7);
      s0 = start_cnt;
      req0 = 1'b1;
      wait_ack(1'b0, 60, w);
      @(negedge clk);
      check("t1_starts", start_cnt - s0, 1);
      check("t1_no_ack1", ack1_cnt, 0);
      check("t1_idle", dbg_state, S_IDLE);

      // simultaneous requests right after reset: 0 wins first
      do_reset();
      dvd0 = 8'd20; dvs0 = 8'd3; dvd1 = 8'd9; dvs1 = 8'd4;
      push_exp(1'b0, 1'b0, 8'd6, 8'd2, 8'd20, 8'd3);
      push_exp(1'b1, 1'b0, 8'd2, 8'd1, 8'd9, 8'd4);
      s0 = start_cnt;
      req0 = 1'b1; req1 = 1'b1;
      wait_ack(1'b0, 60, w);
      wait_ack(1'b1, 60, w);
      @(negedge clk);
      check("t2_starts", start_cnt - s0, 2);
      check("t2_queue_empty", exp_q.size(), 0);
      repeat ($urandom_range(1, 3)) @(negedge clk);

      // divide by zero on requester 1
      dvd1 = 8'd55; dvs1 = 8'd0;
      push_exp(1'b1, 1'b1, 8'hFF, 8'd55, 8'd55, 8'd0);
      s0 = start_cnt;
      req1 = 1'b1;
      wait_ack(1'b1, 10, w);
      check("t3_latency", w, 1);
      @(negedge clk);
      check("t3_no_start", start_cnt - s0, 0);
      repeat ($urandom_range(1, 3)) @(negedge clk);

      // timeout: divider never answers
      model_never = 1'b1;
      dvd0 = 8'd30; dvs0 = 8'd5;
      push_exp(1'b0, 1'b1, 8'd0, 8'd0, 8'd30, 8'd5);
      s0 = start_cnt;
      req0 = 1'b1;
      wait_ack(1'b0, 80, w);
      check("t4_latency", w, 2 + TIMEOUT + 1);
      @(negedge clk);
      check("t4_starts", start_cnt - s0, 1);
      model_never = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);

      // reset five cycles into RUN
      dvd0 = 8'd40; dvs0 = 8'd6;
      req0 = 1'b1;
      n = 0;
      while (dbg_state !== S_RUN && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("t5_reached_run", dbg_state, S_RUN);
      repeat (5) @(negedge clk);
      a0 = ack0_cnt;
      reset = 1'b0;
      req0 = 1'b0;
      #1;
      check("t5_busy_async", busy, 1'b0);
      check("t5_start_async", div_start, 1'b0);
      check("t5_state_async", dbg_state, S_IDLE);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      n = 0;
      while (model_busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("t5_model_idle", model_busy, 1'b0);
      repeat (3) @(negedge clk);
      check("t5_no_late_ack", ack0_cnt - a0, 0);
      check("t5_still_idle", dbg_state, S_IDLE);
      dvd0 = 8'd50; dvs0 = 8'd7;
      push_exp(1'b0, 1'b0, 8'd7, 8'd1, 8'd50, 8'd7);
      req0 = 1'b1;
      wait_ack(1'b0, 60, w);
      repeat (2) @(negedge clk);

      // back-to-back dual requests alternate 0,1,0,1
      do_reset();
      dvd0 = 8'd12; dvs0 = 8'd5; dvd1 = 8'd200; dvs1 = 8'd9;
      push_exp(1'b0, 1'b0, 8'd2, 8'd2, 8'd12, 8'd5);
      push_exp(1'b1, 1'b0, 8'd22, 8'd2, 8'd200, 8'd9);
      s0 = start_cnt;
      req0 = 1'b1; req1 = 1'b1;
      wait_ack(1'b0, 60, w);
      @(negedge clk);
      dvd0 = 8'd77; dvs0 = 8'd8;
      push_exp(1'b0, 1'b0, 8'd9, 8'd5, 8'd77, 8'd8);
      req0 = 1'b1;
      wait_ack(1'b1, 60, w);
      @(negedge clk);
      dvd1 = 8'd255; dvs1 = 8'd16;
      push_exp(1'b1, 1'b0, 8'd15, 8'd15, 8'd255, 8'd16);
      req1 = 1'b1;
      wait_ack(1'b0, 60, w);
      wait_ack(1'b1, 60, w);
      @(negedge clk);
      check("t6_starts", start_cnt - s0, 4);
      check("t6_queue_empty", exp_q.size(), 0);

      // final report
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
